// File: rtl/key_matrix_scanner.sv
// Row-by-row key matrix scanner with per-key debounce.
// Emits one valid/ready event per debounced press or release.
module key_matrix_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [COLS-1:0]   col_n,
    output logic [ROWS-1:0]   row_n,
    output logic              event_valid,
    input  logic              event_ready,
    output logic [CODE_W-1:0] event_code,
    output logic              event_press
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam int NK = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        EMIT,
        ADV
    } state_e;

    state_e              state_q;
    logic [COLS-1:0]     sync1_q;
    logic [COLS-1:0]     sync2_q;
    logic [COLS-1:0]     col_cap_q;
    logic [RW-1:0]       r_q;
    logic [CW-1:0]       c_q;
    logic [NK-1:0]       stable_q;
    logic [NW-1:0]       cnt_q [NK];
    logic [ROWS-1:0]     row_n_q;
    logic                valid_q;
    logic [CODE_W-1:0]   code_q;
    logic                press_q;

    logic [CODE_W-1:0]   key_idx;
    logic                raw;
    logic                last_col;
    logic                flip;
    logic [RW-1:0]       r_d;
    logic [NW-1:0]       cnt_d;

    always_comb begin
        key_idx  = CODE_W'(int'(r_q) * COLS + int'(c_q));
        raw      = ~col_cap_q[c_q];
        last_col = (c_q == CW'(COLS - 1));
        r_d      = (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
        cnt_d    = cnt_q[key_idx] + 1'b1;
        flip     = (raw != stable_q[key_idx]) && (cnt_d == NW'(DEBOUNCE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= '1;
            sync2_q   <= '1;
            col_cap_q <= '1;
            r_q       <= '0;
            c_q       <= '0;
            stable_q  <= '0;
            for (int k = 0; k < NK; k++) begin
                cnt_q[k] <= '0;
            end
            row_n_q   <= ~ROWS'(1);
            valid_q   <= 1'b0;
            code_q    <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        col_cap_q <= sync2_q;
                        c_q       <= '0;
                        state_q   <= EVAL;
                    end
                end
                EVAL: begin
                    if (raw == stable_q[key_idx]) begin
                        cnt_q[key_idx] <= '0;
                    end else if (flip) begin
                        stable_q[key_idx] <= raw;
                        cnt_q[key_idx]    <= '0;
                        code_q            <= key_idx;
                        press_q           <= raw;
                        valid_q           <= 1'b1;
                        state_q           <= EMIT;
                    end else begin
                        cnt_q[key_idx] <= cnt_d;
                    end
                    if (!flip) begin
                        if (last_col) state_q <= ADV;
                        else          c_q     <= c_q + 1'b1;
                    end
                end
                EMIT: begin
                    // payload frozen until the consumer takes it
                    if (event_ready) begin
                        valid_q <= 1'b0;
                        if (last_col) begin
                            state_q <= ADV;
                        end else begin
                            c_q     <= c_q + 1'b1;
                            state_q <= EVAL;
                        end
                    end
                end
                ADV: begin
                    r_q     <= r_d;
                    row_n_q <= ~(ROWS'(1) << r_d);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_n       = row_n_q;
    assign event_valid = valid_q;
    assign event_code  = code_q;
    assign event_press = press_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: 4x4 matrix, debounce 4.
// Pass-level key model plus directed table and stall/reset sequences.
module tb_key_matrix_scanner;

    localparam int R = 4;
    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       event_valid;
    logic       event_ready;
    logic [3:0] event_code;
    logic       event_press;

    always #5 clk = ~clk;

    key_matrix_scanner #(
        .ROWS(R),
        .COLS(C),
        .DEBOUNCE(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .col_n(col_n),
        .row_n(row_n),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_code(event_code),
        .event_press(event_press)
    );

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } ev_t;

    typedef struct {
        logic k21;
        int   nev;
        logic press;
    } vec_t;

    ev_t obs[$];
    ev_t expq[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  r_m;
    bit  stab[16];
    int  cnt[16];
    bit  mon_pv;
    bit  mon_pr;
    ev_t mon_pe;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        r_m = 0;
        for (int k = 0; k < 16; k++) begin
            stab[k] = 1'b0;
            cnt[k]  = 0;
        end
        expq.delete();
    endfunction

    // One row evaluation at the granularity of a tick.
    function automatic void model_tick(input logic [3:0] cv);
        for (int c = 0; c < C; c++) begin
            int  k;
            bit  raw;
            ev_t e;
            k   = r_m * C + c;
            raw = !cv[c];
            if (raw == stab[k]) begin
                cnt[k] = 0;
            end else begin
                cnt[k]++;
                if (cnt[k] == D) begin
                    stab[k] = raw;
                    cnt[k]  = 0;
                    e.code  = 4'(k);
                    e.press = raw;
                    expq.push_back(e);
                end
            end
        end
        r_m = (r_m + 1) % R;
    endfunction

    function automatic logic [3:0] cv_of(input logic [15:0] keys);
        return ~keys[r_m*4 +: 4];
    endfunction

    task automatic send_tick(input logic [3:0] cv, input bit toggle);
        logic [3:0] er;
        er = ~(4'b0001 << r_m);
        chk("row_drive", row_n, er);
        col_n = toggle ? 4'($urandom) : cv;
        step();
        col_n = cv;
        step();
        col_n = cv;
        step();
        tick = 1'b1;
        if (toggle) col_n = 4'($urandom);
        step();
        tick = 1'b0;
        model_tick(cv);
    endtask

    task automatic finish_row(input bit rnd_ready, input bit toggle);
        logic [3:0] en;
        bit done;
        en   = ~(4'b0001 << r_m);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            event_ready = rnd_ready ? 1'($urandom) : 1'b1;
            if (toggle) col_n = 4'($urandom);
            step();
            if (row_n == en) done = 1'b1;
        end
        event_ready = 1'b1;
        chk("row_adv", row_n, en);
    endtask

    task automatic cmp_events(input string nm);
        ev_t a;
        ev_t e;
        chk({nm, "_count"}, obs.size(), expq.size());
        while (obs.size() > 0 && expq.size() > 0) begin
            a = obs.pop_front();
            e = expq.pop_front();
            chk({nm, "_event"}, a, e);
        end
        obs.delete();
        expq.delete();
    endtask

    // Handshake capture and payload-hold checks.
    initial begin
        mon_pv = 1'b0;
        mon_pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pv = 1'b0;
            end else begin
                if (mon_pv && !mon_pr) begin
                    chk("hold_valid", event_valid, 1);
                    chk("hold_payload", {event_code, event_press}, mon_pe);
                end
                if (event_valid && event_ready)
                    obs.push_back({event_code, event_press});
                mon_pv = event_valid;
                mon_pr = event_ready;
                mon_pe = {event_code, event_press};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[18];
        logic [0:17] kpat;
        logic [15:0] rk;
        logic [3:0]  cv;

        kpat = 18'b111011111100010000;
        for (int i = 0; i < 18; i++) tbl[i] = '{kpat[i], 0, 1'b0};
        tbl[7].nev    = 1;
        tbl[7].press  = 1'b1;
        tbl[17].nev   = 1;
        tbl[17].press = 1'b0;

        rst = 1'b1;
        tick = 1'b0;
        col_n = '1;
        event_ready = 1'b1;
        model_reset();
        step();
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_valid", event_valid, 0);
        chk("rst_code", event_code, 0);
        chk("rst_press", event_press, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_row_n", row_n, 4'b1110);

        // idle stepping, no keys
        for (int t = 0; t < 8; t++) begin
            send_tick(4'hF, 1'b0);
            finish_row(1'b0, 1'b0);
        end
        chk("idle_events", obs.size(), 0);
        chk("idle_row_n", row_n, 4'b1110);
        obs.delete();
        expq.delete();

        // key (2,1) debounce table, one record per full pass
        for (int p = 0; p < 18; p++) begin
            rk = tbl[p].k21 ? 16'h0200 : 16'h0000;
            for (int t = 0; t < R; t++) begin
                send_tick(cv_of(rk), 1'b0);
                finish_row(1'b0, 1'b0);
            end
            chk("tbl_nev", obs.size(), tbl[p].nev);
            if (obs.size() > 0) begin
                chk("tbl_code", obs[0].code, 9);
                chk("tbl_press", obs[0].press, tbl[p].press);
            end
            obs.delete();
            expq.delete();
        end

        // keys (1,0)+(1,3) with consumer stall and dropped tick
        rk = 16'h0090;
        for (int i = 0; i < 16 && !(r_m == 1 && cnt[4] == D - 1); i++) begin
            send_tick(cv_of(rk), 1'b0);
            finish_row(1'b0, 1'b0);
            cmp_events("stall_pre");
        end
        event_ready = 1'b0;
        send_tick(cv_of(rk), 1'b0);
        for (int i = 0; i < 20 && !event_valid; i++) step();
        chk("stall_valid", event_valid, 1);
        for (int i = 0; i < 20; i++) begin
            tick = (i == 10);
            step();
            chk("stall_code", event_code, 4);
            chk("stall_press", event_press, 1);
        end
        tick = 1'b0;
        chk("stall_row_n", row_n, 4'b1101);
        finish_row(1'b0, 1'b0);
        cmp_events("stall");
        for (int i = 0; i < 10; i++) step();
        chk("tick_dropped", row_n, 4'b1011);

        // columns toggling between ticks
        rk = 16'($urandom);
        for (int t = 0; t < 20; t++) begin
            send_tick(cv_of(rk), 1'b1);
            finish_row(1'b0, 1'b1);
            cmp_events("toggle");
        end

        // random keys, bounce and backpressure
        for (int t = 0; t < 64; t++) begin
            if ($urandom_range(0, 2) == 0) rk[$urandom_range(0, 15)] ^= 1'b1;
            cv = cv_of(rk);
            if ($urandom_range(0, 5) == 0) cv = 4'($urandom);
            send_tick(cv, 1'b0);
            finish_row(1'b1, 1'b0);
            cmp_events("rand");
        end

        // reset while an event is pending
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        obs.delete();
        step();
        rk = 16'h4000;
        for (int i = 0; i < 16 && !(r_m == 3 && cnt[14] == D - 1); i++) begin
            send_tick(cv_of(rk), 1'b0);
            finish_row(1'b0, 1'b0);
            cmp_events("pre_rst");
        end
        event_ready = 1'b0;
        send_tick(cv_of(rk), 1'b0);
        for (int i = 0; i < 20 && !event_valid; i++) step();
        chk("emit_before_rst", event_valid, 1);
        chk("emit_code_before_rst", event_code, 14);
        rst = 1'b1;
        #1;
        chk("midrst_row_n", row_n, 4'b1110);
        chk("midrst_valid", event_valid, 0);
        chk("midrst_code", event_code, 0);
        chk("midrst_press", event_press, 0);
        step();
        step();
        rst = 1'b0;
        event_ready = 1'b1;
        model_reset();
        obs.delete();
        step();
        for (int t = 0; t < R * D; t++) begin
            send_tick(cv_of(rk), 1'b0);
            finish_row(1'b0, 1'b0);
            cmp_events("post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
